// File: rtl/instr_dispatch_pkg.sv
// Shared definitions for the instruction dispatch stage: branch/commit-ID
// sizing, FSM state constants, pending-mask layout and the slot payload.
package instr_dispatch_pkg;

  // Branch and commit-ID sizing shared with the decode and commit stages.
  localparam int N_INSTR_BRANCHES = 4;
  localparam int INSTR_BRANCH_MAC = 2;
  localparam int COMMIT_ID_WIDTH  = 4;
  localparam int BRANCH_W         = $clog2(N_INSTR_BRANCHES);

  // Pending mask: 16 channel registers plus the accumulator on top.
  localparam int PEND_W  = 17;
  localparam int ACC_BIT = 16;

  // FSM states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Fixed-width part of a slot payload; the block index is prepended by
  // the top because its width follows n_blocks.
  typedef struct packed {
    logic [3:0]                 src_a;
    logic [3:0]                 src_b;
    logic [3:0]                 dest;
    logic [COMMIT_ID_WIDTH-1:0] cid;
    logic                       flag;
  } slot_fix_t;

  // One-hot pending bit for a channel register.
  function automatic logic [PEND_W-1:0] ch_bit(input logic [3:0] ch);
    return PEND_W'(1) << ch;
  endfunction

endpackage

// File: rtl/instr_dispatch_slot.sv
// dispatch_slot: single-entry valid/ready payload register feeding one
// execution branch. A load on the same cycle as a drain keeps valid high.
module dispatch_slot
  import instr_dispatch_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         drain_ready,
  output logic         valid,
  output logic [W-1:0] data
);

  // Hold payload until the branch takes it; refill wins over drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (enable) begin
      if (load) begin
        valid <= 1'b1;
        data  <= load_data;
      end else if (valid && drain_ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/instr_dispatch.sv
// instr_dispatch: issue stage in front of commit. Tags instructions with a
// sequential commit ID, routes them to per-branch slots and stalls on
// register/accumulator hazards and a full commit-ID window.
// Optional feature macro: DISPATCH_SCOREBOARD_EN (pending-mask hazard
// tracking). Without it issue is fully serial.
module instr_dispatch
  import instr_dispatch_pkg::*;
#(
  parameter int data_width = 16,
  parameter int n_blocks   = 256
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              enable,
  input  logic                                              sample_tick,
  input  logic                                              instr_valid,
  output logic                                              instr_ready,
  input  logic [$clog2(n_blocks)-1:0]                       instr_block,
  input  logic [BRANCH_W-1:0]                               instr_branch,
  input  logic [3:0]                                        instr_src_a,
  input  logic [3:0]                                        instr_src_b,
  input  logic [3:0]                                        instr_dest,
  input  logic                                              instr_writes_ch,
  input  logic                                              instr_reads_acc,
  input  logic                                              instr_flag,
  input  logic                                              instr_last,
  output logic [N_INSTR_BRANCHES-1:0]                       out_valid,
  input  logic [N_INSTR_BRANCHES-1:0]                       out_ready,
  output logic [N_INSTR_BRANCHES-1:0][$clog2(n_blocks)-1:0] out_block,
  output logic [N_INSTR_BRANCHES-1:0][3:0]                  out_src_a,
  output logic [N_INSTR_BRANCHES-1:0][3:0]                  out_src_b,
  output logic [N_INSTR_BRANCHES-1:0][3:0]                  out_dest,
  output logic [N_INSTR_BRANCHES-1:0][COMMIT_ID_WIDTH-1:0]  out_commit_id,
  output logic [N_INSTR_BRANCHES-1:0]                       out_commit_flag,
  input  logic [COMMIT_ID_WIDTH-1:0]                        next_commit_id,
  input  logic                                              channel_write_enable,
  input  logic [3:0]                                        channel_write_addr,
  input  logic                                              accumulator_write_enable,
  output logic                                              program_done,
  output logic                                              overrun
);

  localparam int BLOCK_W = $clog2(n_blocks);
  localparam int FIX_W   = $bits(slot_fix_t);
  localparam int SLOT_W  = BLOCK_W + FIX_W;
  // Sample width is not consumed here; kept for parity with sibling stages.
  localparam int unused_data_width = data_width;

  logic [1:0]                           state;
  logic [COMMIT_ID_WIDTH-1:0]           dispatch_id;
  logic [COMMIT_ID_WIDTH-1:0]           in_flight;
  logic                                 win_full;
  logic                                 is_mac;
  logic                                 slot_free;
  logic                                 issue_ok;
  logic                                 drained;
  logic                                 accept;
  logic [N_INSTR_BRANCHES-1:0]          slot_load;
  logic [SLOT_W-1:0]                    slot_in;
  logic [N_INSTR_BRANCHES-1:0][SLOT_W-1:0] slot_q;
  slot_fix_t                            fix_in;

  // Window: IDs handed out but not yet committed; one short of 2^W so an
  // ID is never reused while still in flight.
  assign in_flight = dispatch_id - next_commit_id;
  assign win_full  = &in_flight;
  assign is_mac    = (instr_branch == BRANCH_W'(INSTR_BRANCH_MAC));
  assign slot_free = !out_valid[instr_branch] || out_ready[instr_branch];

`ifdef DISPATCH_SCOREBOARD_EN
  logic [PEND_W-1:0]  pending;
  logic [PEND_W-1:0]  pend_set;
  logic [PEND_W-1:0]  pend_clr;
  logic [ACC_BIT-1:0] ch_pend;
  logic               hazard;

  assign ch_pend = pending[ACC_BIT-1:0];
  // Registered mask only: a commit-stage clear is visible next cycle.
  assign hazard  = ch_pend[instr_src_a] | ch_pend[instr_src_b]
                 | (instr_writes_ch & ch_pend[instr_dest])
                 | ((instr_reads_acc | is_mac) & pending[ACC_BIT]);
  assign issue_ok = !hazard && !win_full;
  assign drained  = (in_flight == '0) && (pending == '0);

  // Pending bits set by accepted writers, cleared by commit-stage strobes.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (accept && instr_writes_ch) pend_set = pend_set | ch_bit(instr_dest);
    if (accept && is_mac)          pend_set[ACC_BIT] = 1'b1;
    if (channel_write_enable)      pend_clr = pend_clr | ch_bit(channel_write_addr);
    if (accumulator_write_enable)  pend_clr[ACC_BIT] = 1'b1;
  end

  // Pending mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pending <= '0;
    else if (enable) pending <= (pending & ~pend_clr) | pend_set;
  end
`else
  logic unused_sb;
  // Serial issue: only when nothing is in flight and every slot is empty.
  assign issue_ok  = (in_flight == '0) && (out_valid == '0);
  assign drained   = (in_flight == '0);
  assign unused_sb = ^{instr_writes_ch, instr_reads_acc, channel_write_enable,
                       channel_write_addr, accumulator_write_enable, is_mac, win_full};
`endif

  assign instr_ready  = enable && (state == ST_RUN) && slot_free && issue_ok;
  assign accept       = instr_valid && instr_ready;
  assign program_done = (state == ST_DONE);

  assign fix_in  = '{src_a: instr_src_a, src_b: instr_src_b, dest: instr_dest,
                     cid: dispatch_id, flag: instr_flag};
  assign slot_in = {instr_block, fix_in};

  for (genvar b = 0; b < N_INSTR_BRANCHES; b++) begin : g_slot
    slot_fix_t fix_q;
    assign slot_load[b] = accept && (instr_branch == BRANCH_W'(b));
    dispatch_slot #(.W(SLOT_W)) u_slot (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .load       (slot_load[b]),
      .load_data  (slot_in),
      .drain_ready(out_ready[b]),
      .valid      (out_valid[b]),
      .data       (slot_q[b])
    );
    assign fix_q              = slot_q[b][FIX_W-1:0];
    assign out_block[b]       = slot_q[b][SLOT_W-1:FIX_W];
    assign out_src_a[b]       = fix_q.src_a;
    assign out_src_b[b]       = fix_q.src_b;
    assign out_dest[b]        = fix_q.dest;
    assign out_commit_id[b]   = fix_q.cid;
    assign out_commit_flag[b] = fix_q.flag;
  end

  // Run FSM, commit-ID counter and sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      dispatch_id <= '0;
      overrun     <= 1'b0;
    end else if (enable) begin
      if (accept)                           dispatch_id <= dispatch_id + 1'b1;
      if (sample_tick && state != ST_IDLE)  overrun <= 1'b1;
      case (state)
        ST_IDLE:  if (sample_tick)           state <= ST_RUN;
        ST_RUN:   if (accept && instr_last)  state <= ST_DRAIN;
        ST_DRAIN: if (drained)               state <= ST_DONE;
        ST_DONE:                             state <= ST_IDLE;
        default:                             state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_dispatch.sv
// Self-checking bench for instr_dispatch. A reference model tracks runs,
// commit IDs, outstanding writers and slot contents; a small commit-stage
// emulation retires instructions in ID order and drives the write strobes.
module tb_instr_dispatch;
  import instr_dispatch_pkg::*;

  localparam int NB  = N_INSTR_BRANCHES;
  localparam int W   = COMMIT_ID_WIDTH;
  localparam int WIN = 1 << W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b1;
  logic sample_tick = 1'b0;
  logic instr_valid = 1'b0;
  logic instr_ready;
  logic [7:0] instr_block = '0;
  logic [BRANCH_W-1:0] instr_branch = '0;
  logic [3:0] instr_src_a = '0, instr_src_b = '0, instr_dest = '0;
  logic instr_writes_ch = 1'b0, instr_reads_acc = 1'b0, instr_flag = 1'b0, instr_last = 1'b0;
  logic [NB-1:0] out_valid;
  logic [NB-1:0] out_ready = '0;
  logic [NB-1:0][7:0] out_block;
  logic [NB-1:0][3:0] out_src_a, out_src_b, out_dest;
  logic [NB-1:0][W-1:0] out_commit_id;
  logic [NB-1:0] out_commit_flag;
  logic [W-1:0] next_commit_id = '0;
  logic channel_write_enable = 1'b0;
  logic [3:0] channel_write_addr = '0;
  logic accumulator_write_enable = 1'b0;
  logic program_done, overrun;

  instr_dispatch #(.data_width(16), .n_blocks(256)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_tick(sample_tick),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_block(instr_block),
    .instr_branch(instr_branch), .instr_src_a(instr_src_a), .instr_src_b(instr_src_b),
    .instr_dest(instr_dest), .instr_writes_ch(instr_writes_ch),
    .instr_reads_acc(instr_reads_acc), .instr_flag(instr_flag), .instr_last(instr_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_src_a(out_src_a), .out_src_b(out_src_b), .out_dest(out_dest),
    .out_commit_id(out_commit_id), .out_commit_flag(out_commit_flag),
    .next_commit_id(next_commit_id), .channel_write_enable(channel_write_enable),
    .channel_write_addr(channel_write_addr),
    .accumulator_write_enable(accumulator_write_enable),
    .program_done(program_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { int id; int br; bit wr; int dest; bit mac; bit drained; } ent_t;
  ent_t cq[$];                 // instructions issued but not yet committed, in ID order
  int   st;                    // 0 idle, 1 run, 2 drain, 3 done
  int   did, ncid;             // next ID to hand out / next ID the commit stage expects
  bit   pend[17];              // outstanding writers: channels 0..15, accumulator 16
  bit   sv[NB];
  int   s_blk[NB], s_a[NB], s_b[NB], s_d[NB], s_id[NB];
  bit   s_fl[NB];
  bit   m_ovr, m_acc, dut_acc;
  bit   commit_en = 1'b1, rnd_ready = 1'b0;
  int   commit_pct = 100, dis_pct = 0;
  logic [NB-1:0] fixed_ready = '1;
  int   cyc, pd_cnt, acc_cyc;
  int   total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int inflight();
    return (did - ncid + WIN) % WIN;
  endfunction

  function automatic bit exp_ready();
    int br;
    bit any;
    br = int'(instr_branch);
    if (reset || !enable || st != 1) return 1'b0;
    if (sv[br] && !out_ready[br]) return 1'b0;
`ifdef DISPATCH_SCOREBOARD_EN
    if (pend[instr_src_a] || pend[instr_src_b]) return 1'b0;
    if (instr_writes_ch && pend[instr_dest]) return 1'b0;
    if ((instr_reads_acc || br == INSTR_BRANCH_MAC) && pend[16]) return 1'b0;
    return inflight() < WIN - 1;
`else
    any = 1'b0;
    for (int b = 0; b < NB; b++) any |= sv[b];
    return inflight() == 0 && !any;
`endif
  endfunction

  function automatic bit no_pending();
    for (int i = 0; i < 17; i++) if (pend[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    st = 0; did = 0; ncid = 0; m_ovr = 0;
    for (int i = 0; i < 17; i++) pend[i] = 0;
    for (int b = 0; b < NB; b++) begin
      sv[b] = 0; s_blk[b] = 0; s_a[b] = 0; s_b[b] = 0; s_d[b] = 0; s_id[b] = 0; s_fl[b] = 0;
    end
    cq.delete();
  endtask

  // One clock: drive commit stage, check outputs at negedge, advance model.
  task automatic cycle();
    bit er, acc, cm, dr;
    ent_t h;
    int br;
    channel_write_enable = 0; accumulator_write_enable = 0; channel_write_addr = 0;
    cm = 0;
    if (commit_en && enable && cq.size() > 0 && cq[0].drained &&
        $urandom_range(99) < commit_pct) begin
      cm = 1; h = cq[0];
      channel_write_enable = h.wr; channel_write_addr = h.dest[3:0];
      accumulator_write_enable = h.mac;
    end
    next_commit_id = ncid[W-1:0];
    out_ready = rnd_ready ? NB'($urandom) : fixed_ready;
    @(negedge clk);
    er = exp_ready();
    chk("instr_ready", instr_ready, er);
    chk("program_done", program_done, st == 3);
    chk("overrun", overrun, m_ovr);
    for (int b = 0; b < NB; b++) begin
      chk("out_valid", out_valid[b], sv[b]);
      if (sv[b]) begin
        chk("out_block", out_block[b], s_blk[b]);
        chk("out_src_a", out_src_a[b], s_a[b]);
        chk("out_src_b", out_src_b[b], s_b[b]);
        chk("out_dest", out_dest[b], s_d[b]);
        chk("out_commit_id", out_commit_id[b], s_id[b]);
        chk("out_commit_flag", out_commit_flag[b], s_fl[b]);
      end
    end
    if (program_done === 1'b1) pd_cnt++;
    dut_acc = instr_valid && (instr_ready === 1'b1);
    acc = er && instr_valid;
    dr = (inflight() == 0);
`ifdef DISPATCH_SCOREBOARD_EN
    dr = dr && no_pending();
`endif
    @(posedge clk);
    if (enable) begin
      for (int b = 0; b < NB; b++)
        if (sv[b] && out_ready[b]) begin
          foreach (cq[i]) if (cq[i].id == s_id[b]) cq[i].drained = 1;
          sv[b] = 0;
        end
      if (cm) begin
        if (h.wr) pend[h.dest] = 0;
        if (h.mac) pend[16] = 0;
        void'(cq.pop_front());
        ncid = (ncid + 1) % WIN;
      end
      if (acc) begin
        br = int'(instr_branch);
        sv[br] = 1; s_blk[br] = instr_block; s_a[br] = instr_src_a; s_b[br] = instr_src_b;
        s_d[br] = instr_dest; s_id[br] = did; s_fl[br] = instr_flag;
        if (instr_writes_ch) pend[instr_dest] = 1;
        if (br == INSTR_BRANCH_MAC) pend[16] = 1;
        cq.push_back('{id: did, br: br, wr: instr_writes_ch, dest: int'(instr_dest),
                       mac: (br == INSTR_BRANCH_MAC), drained: 0});
        did = (did + 1) % WIN;
      end
      if (sample_tick && st != 0) m_ovr = 1;
      case (st)
        0: if (sample_tick) st = 1;
        1: if (acc && instr_last) st = 2;
        2: if (dr) st = 3;
        default: st = 0;
      endcase
    end
    m_acc = acc;
    cyc++;
    #1;
    sample_tick = 0;
  endtask

  task automatic set_instr(input int br, input int a, input int b, input int d,
                           input bit wr, input bit racc, input bit last);
    instr_branch = br[BRANCH_W-1:0]; instr_src_a = a[3:0]; instr_src_b = b[3:0];
    instr_dest = d[3:0]; instr_writes_ch = wr; instr_reads_acc = racc; instr_last = last;
    instr_block = 8'($urandom); instr_flag = 1'($urandom);
  endtask

  // Present one instruction until accepted, bounded.
  task automatic issue(input int br, input int a, input int b, input int d,
                       input bit wr, input bit racc, input bit last);
    set_instr(br, a, b, d, wr, racc, last);
    instr_valid = 1;
    m_acc = 0;
    for (int n = 0; n < 300 && !m_acc; n++) begin
      enable = (dis_pct == 0) || ($urandom_range(99) >= dis_pct);
      cycle();
    end
    chk("issue_accepted", m_acc, 1);
    acc_cyc = cyc - 1;
    instr_valid = 0;
    enable = 1;
  endtask

  task automatic tick();
    sample_tick = 1;
    cycle();
  endtask

  // Let the run drain to IDLE and confirm a single done pulse.
  task automatic finish_prog();
    int p0;
    p0 = pd_cnt;
    instr_valid = 0;
    for (int n = 0; n < 400 && st != 0; n++) cycle();
    chk("run_finished", st, 0);
    chk("done_pulses", pd_cnt - p0, 1);
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    chk("rst_instr_ready", instr_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_program_done", program_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_commit_id", out_commit_id, 0);
    chk("rst_block", out_block, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    int c0, c1, c2, n_acc;
    cyc = 0; pd_cnt = 0;
    model_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    cycle();

    // Three independent ALU instructions to branch 1.
    tick();
    issue(1, 1, 2, 4, 1, 0, 0); c0 = acc_cyc;
    issue(1, 1, 2, 5, 1, 0, 0); c1 = acc_cyc;
    issue(1, 7, 8, 6, 1, 0, 1); c2 = acc_cyc;
`ifdef DISPATCH_SCOREBOARD_EN
    chk("alu_gap01", c1 - c0, 1);
    chk("alu_gap12", c2 - c1, 1);
`else
    chk("alu_gap01", c1 - c0, 3);
    chk("alu_gap12", c2 - c1, 3);
`endif
    finish_prog();

    // RAW on ch3: read accepted the cycle after the ch3 write strobe.
    tick();
    issue(0, 1, 2, 3, 1, 0, 0); c0 = acc_cyc;
    issue(0, 3, 0, 9, 1, 0, 1); c1 = acc_cyc;
    chk("raw_gap", c1 - c0, 3);
    finish_prog();

    // Back-to-back MACs wait on the accumulator strobe.
    tick();
    issue(INSTR_BRANCH_MAC, 1, 2, 0, 0, 1, 0); c0 = acc_cyc;
    issue(INSTR_BRANCH_MAC, 4, 5, 0, 0, 1, 1); c1 = acc_cyc;
    chk("mac_gap", c1 - c0, 3);
    finish_prog();

    // Commit-ID window with the commit stage frozen, then release and wrap.
    tick();
    commit_en = 0;
    instr_valid = 1;
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      set_instr(1, $urandom_range(15), $urandom_range(15), 0, 0, 0, 0);
      cycle();
      if (dut_acc) n_acc++;
    end
    instr_valid = 0;
`ifdef DISPATCH_SCOREBOARD_EN
    chk("window_accepts", n_acc, WIN - 1);
`else
    chk("window_accepts", n_acc, 1);
`endif
    commit_en = 1;
    for (int i = 0; i < 5; i++) issue(1, 0, 0, 0, 0, 0, i == 4);
    finish_prog();

    // Tick during DRAIN sets sticky overrun; run still completes.
    tick();
    commit_en = 0;
    issue(0, 1, 1, 2, 1, 0, 1);
    cycle();
    sample_tick = 1;
    cycle();
    chk("overrun_set", overrun, 1);
    commit_en = 1;
    finish_prog();
    cycle();
    chk("overrun_sticky", overrun, 1);

    // Reset with slots occupied, then restart from commit ID 0.
    do_reset();
    tick();
    commit_en = 0; fixed_ready = '0;
    issue(0, 1, 2, 3, 0, 0, 0);
`ifdef DISPATCH_SCOREBOARD_EN
    issue(1, 4, 5, 6, 0, 0, 0);
`endif
    cycle();
    do_reset();
    commit_en = 1; fixed_ready = '1;
    tick();
    issue(3, 1, 2, 3, 1, 0, 1);
    cycle();
    chk("restart_id", out_commit_id[3], 0);
    finish_prog();

    // Randomized programs with random backpressure, commit delay, enable gaps.
    rnd_ready = 1; commit_pct = 60; dis_pct = 10;
    for (int p = 0; p < 5; p++) begin
      tick();
      for (int i = 0; i < 14; i++)
        issue($urandom_range(NB - 1), $urandom_range(15), $urandom_range(15),
              $urandom_range(15), 1'($urandom), 1'($urandom), i == 13);
      finish_prog();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
